sram_port_arbiter: RTL
======================

# sram_port_arbiter

Round-robin arbiter that shares one single-port `sram` instance between `NUM_REQ` requesters, such as the DMA fill engine, the PE-array operand fetch and the writeback unit.
- Each cycle it grants at most one request and drives the SRAM enable, write-enable, address and write-data.
- It returns read data to the issuing requester one cycle later.
- An optional per-requester lock lets a requester keep ownership for bursts of up to `LOCK_MAX` consecutive beats.

## Interface
Parameters:
- `DATA_WIDTH`, 32, SRAM word width.
- `N_ENTRIES`, 1024, SRAM depth; `AW = $clog2(N_ENTRIES)`.
- `NUM_REQ`, 4, number of requesters (≥2).
- `LOCK_MAX`, 8, maximum consecutive locked beats (≥1).

Ports:
- `clk_i` input 1: clock, rising edge.
- `rst_ni` input 1: reset, asynchronous, active-low.
- `req_valid_i` input NUM_REQ: request valid, per requester.
- `req_we_i` input NUM_REQ: 1 = write, 0 = read.
- `req_lock_i` input NUM_REQ: request to keep the grant after this beat.
- `req_addr_i` input NUM_REQ*AW: flattened addresses; requester i uses bits [i*AW +: AW].
- `req_wdata_i` input NUM_REQ*DATA_WIDTH: flattened write data.
- `req_ready_o` output NUM_REQ: one-hot grant; a beat transfers when valid & ready.
- `rsp_valid_o` output NUM_REQ: one-hot read-data-valid.
- `rsp_data_o` output DATA_WIDTH: read data; valid only while some `rsp_valid_o` bit is high.
- `sram_en_o` output 1: SRAM enable.
- `sram_we_o` output 1: SRAM write enable.
- `sram_addr_o` output AW: SRAM address.
- `sram_wdata_o` output DATA_WIDTH: SRAM write data.
- `sram_rdata_i` input DATA_WIDTH: SRAM registered read data.

## Operation
- **States.**
  - ARB: round-robin arbitration among the asserted `req_valid_i`.
  - LOCKED: only the owner is eligible.
- **Round-robin pointer `last`.**
  - Reset value is NUM_REQ-1, so requester 0 has top priority first.
  - Search order is last+1, last+2, … modulo NUM_REQ.
  - On every transfer, `last` ← granted index.
- **Grant is combinational from the current-cycle `req_valid_i` and the state.**
  - `req_ready_o` has at most one bit set.
  - It is all zeros when no eligible requester is valid.
- **SRAM drive.**
  - `sram_en_o` = |`req_ready_o`.
  - `sram_we_o`, `sram_addr_o` and `sram_wdata_o` are muxed from the granted requester.
  - When idle, `sram_we_o` = 0 and addr/wdata = 0.
- **Read response.**
  - Register `rd_tag` (one-hot) ← `req_ready_o & ~req_we_i` at each edge.
  - `rsp_valid_o` = `rd_tag`.
  - `rsp_data_o` = `sram_rdata_i`, passed through.
  - Responses have no backpressure; requesters must accept them.
- **Lock.**
  - Counter `beat_cnt`, width `$clog2(LOCK_MAX+1)`, counts beats of the current burst, including the first beat.
  - A transfer with `req_lock_i[g]` = 1 and post-transfer count < LOCK_MAX → LOCKED, owner = g.
  - Otherwise → ARB with `beat_cnt` = 0.
- **In LOCKED:**
  - If the owner's valid is high, it is granted unconditionally and the lock rule is re-evaluated after the beat.
  - If the owner's valid is low, the lock is released that same cycle: normal round-robin arbitration runs immediately among the others, and the state returns to ARB.
  - At LOCK_MAX beats the lock is forced to release regardless of `req_lock_i`; `last` = owner, so the next grant goes to another requester if any is valid.
- **Writes** produce no response.
- **Reset.** Asynchronous assertion clears `rd_tag`, `beat_cnt`, state (→ARB) and `last` (→NUM_REQ-1). An in-flight read response is dropped.

## Timing
- Request to SRAM: 0 cycles (combinational grant).
- Read latency: the response appears on the cycle after the accepted beat, for one cycle.
- Throughput: one beat per cycle; back-to-back reads from different requesters give back-to-back one-hot `rsp_valid_o`.
- Output reset values:
  - `req_ready_o`, `sram_en_o`, `sram_we_o`, `sram_addr_o`, `sram_wdata_o`: 0 (while `req_valid_i` = 0).
  - `rsp_valid_o`: 0.
  - `rsp_data_o` follows `sram_rdata_i`.
- A requester must hold its valid, addr, wdata and lock stable until ready.

## Test plan
- **Round-robin fairness.** Reset, then hold all four `req_valid_i` with reads at addr i*16.
  - Grants: 0,1,2,3,0,…
  - Each `rsp_valid_o` bit fires one cycle after its grant, with data = `RAM[i*16]`.
- **Write then read.** Requester 2 writes 0xDEADBEEF at addr 5, then requester 0 reads addr 5.
  - `rsp_valid_o` = 0b0001 with `rsp_data_o` = 0xDEADBEEF.
  - No response is generated for the write.
- **Lock burst cap.** LOCK_MAX=8. Requester 1 holds lock and valid for 12 beats while requester 3 is valid.
  - Requester 1 gets 8 consecutive grants, then requester 3 gets the 9th cycle.
- **Lock early release.** Requester 0 is locked and drops valid after 3 beats while requester 2 is valid.
  - Requester 2 is granted in that same cycle and the state returns to ARB.
- **Reset mid-read.** Requester 1's read is accepted, then `rst_ni` is pulsed low before the next edge.
  - `rsp_valid_o` stays 0 and the next grant order restarts at requester 0.
- **Idle.** No valids for 10 cycles.
  - `sram_en_o` = 0 and `rsp_valid_o` = 0 throughout; `last` is unchanged.

Source files
------------

// File: rtl/sram_port_arbiter_if.sv
// Requester/SRAM bundle shared by sram_port_arbiter and its environment.
//   req_valid/req_we/req_lock : per-requester request qualifiers (NUM_REQ bits)
//   req_addr/req_wdata        : flattened per-requester address / write data
//   req_ready                 : one-hot grant back to requesters
//   rsp_valid/rsp_data        : one-hot read response tag and read data
//   sram_en/we/addr/wdata     : single-port SRAM command
//   sram_rdata                : SRAM registered read data
// Modports: slave = arbiter side, master = requesters + SRAM side.
interface sram_port_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned N_ENTRIES  = 1024,
  parameter int unsigned NUM_REQ    = 4
);
  localparam int unsigned AW = $clog2(N_ENTRIES);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_we;
  logic [NUM_REQ-1:0]            req_lock;
  logic [NUM_REQ*AW-1:0]         req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]         rsp_data;
  logic                          sram_en;
  logic                          sram_we;
  logic [AW-1:0]                 sram_addr;
  logic [DATA_WIDTH-1:0]         sram_wdata;
  logic [DATA_WIDTH-1:0]         sram_rdata;

  modport slave (
    input  req_valid, req_we, req_lock, req_addr, req_wdata, sram_rdata,
    output req_ready, rsp_valid, rsp_data, sram_en, sram_we, sram_addr, sram_wdata
  );

  modport master (
    output req_valid, req_we, req_lock, req_addr, req_wdata, sram_rdata,
    input  req_ready, rsp_valid, rsp_data, sram_en, sram_we, sram_addr, sram_wdata
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between NUM_REQ requesters.
// Grants at most one beat per cycle (combinational grant), returns read data one
// cycle later tagged one-hot, and supports lock bursts of up to LOCK_MAX beats.
// Ports:
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous active-low reset
//   bus    : sram_port_arbiter_if.slave (requests, grant, response, SRAM command)
// The interface instance must use the same DATA_WIDTH/N_ENTRIES/NUM_REQ.
module sram_port_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned N_ENTRIES  = 1024,
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned LOCK_MAX   = 8
) (
  input logic               clk_i,
  input logic               rst_ni,
  sram_port_arbiter_if.slave bus
);
  localparam int unsigned AW   = $clog2(N_ENTRIES);
  localparam int unsigned IdxW = $clog2(NUM_REQ);
  localparam int unsigned CntW = $clog2(LOCK_MAX + 1);

  typedef enum logic [0:0] {StArb, StLocked} state_e;

  state_e              state_q, state_d;
  logic [IdxW-1:0]     owner_q, owner_d;
  logic [IdxW-1:0]     last_q, last_d;
  logic [CntW-1:0]     beat_cnt_q, beat_cnt_d;
  logic [NUM_REQ-1:0]  rd_tag_q, rd_tag_d;

  logic                gnt_found;
  logic                own_gnt;
  logic [IdxW-1:0]     gnt_idx;
  logic [IdxW-1:0]     cand_idx;
  logic [CntW-1:0]     cnt_post;
  logic [NUM_REQ-1:0]  ready;

  // Grant selection: the owner wins while locked and valid; otherwise search
  // last+1, last+2, ... so the most recent winner has lowest priority.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand_idx  = '0;
    own_gnt   = (state_q == StLocked) && bus.req_valid[owner_q];
    if (own_gnt) begin
      gnt_found = 1'b1;
      gnt_idx   = owner_q;
    end else begin
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
        cand_idx = IdxW'((32'(last_q) + k) % NUM_REQ);
        if (!gnt_found && bus.req_valid[cand_idx]) begin
          gnt_found = 1'b1;
          gnt_idx   = cand_idx;
        end
      end
    end
  end

  // SRAM command mux; idle drives zeros.
  always_comb begin
    ready          = '0;
    bus.sram_we    = 1'b0;
    bus.sram_addr  = '0;
    bus.sram_wdata = '0;
    if (gnt_found) begin
      ready[gnt_idx] = 1'b1;
      bus.sram_we    = bus.req_we[gnt_idx];
      bus.sram_addr  = bus.req_addr[32'(gnt_idx)*AW +: AW];
      bus.sram_wdata = bus.req_wdata[32'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign bus.req_ready = ready;
  assign bus.sram_en   = gnt_found;
  assign bus.rsp_valid = rd_tag_q;
  assign bus.rsp_data  = bus.sram_rdata;

  // Next-state: lock re-evaluated after every transfer; a cycle without a
  // grant always ends any lock (owner dropped valid, nobody else asked).
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    beat_cnt_d = beat_cnt_q;
    cnt_post   = '0;
    rd_tag_d   = ready & ~bus.req_we;
    if (gnt_found) begin
      last_d   = gnt_idx;
      cnt_post = own_gnt ? beat_cnt_q + CntW'(1) : CntW'(1);
      if (bus.req_lock[gnt_idx] && (cnt_post < CntW'(LOCK_MAX))) begin
        state_d    = StLocked;
        owner_d    = gnt_idx;
        beat_cnt_d = cnt_post;
      end else begin
        state_d    = StArb;
        beat_cnt_d = '0;
      end
    end else begin
      state_d    = StArb;
      beat_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StArb;
      owner_q    <= '0;
      last_q     <= IdxW'(NUM_REQ - 1);
      beat_cnt_q <= '0;
      rd_tag_q   <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      beat_cnt_q <= beat_cnt_d;
      rd_tag_q   <= rd_tag_d;
    end
  end
endmodule
